// File: rtl/pkt_tx_gen_pkg.sv
// Shared constants for the packet generator and its receive-side checker.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: ctrl byte codes, module-header field positions, FSM state encoding.
package pkt_tx_gen_pkg;

  localparam logic [7:0] CTRL_MODULE_HDR = 8'hFF;
  localparam logic [7:0] CTRL_PAYLOAD    = 8'h00;

  // Module header word layout: {dst_port, word_len, src_port, byte_len}
  localparam int HDR_DST_LSB  = 48;
  localparam int HDR_WLEN_LSB = 32;
  localparam int HDR_SRC_LSB  = 16;
  localparam int HDR_BLEN_LSB = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/pkt_tx_gen_if.sv
// Word-stream bus between a packet source and a datapath input port.
// Latency: n/a (wires only).
// Backpressure: out_rdy from the sink gates every word the source issues.
// Ports: out_data/out_ctrl/out_wr from source (master), out_rdy from sink (slave).
interface pkt_tx_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (output out_data, output out_ctrl, output out_wr, input out_rdy);
  modport slave  (input out_data, input out_ctrl, input out_wr, output out_rdy);
endinterface

// File: rtl/pkt_len_calc.sv
// Derives word count, last-word ctrl byte and last-word byte mask from a byte length.
// Latency: combinational.
// Backpressure: none.
// Ports: len_bytes in; word_len, last_ctrl (one-hot end marker), last_mask (valid bytes MSB-first) out.
module pkt_len_calc (
  input  logic [15:0] len_bytes,
  output logic [15:0] word_len,
  output logic [7:0]  last_ctrl,
  output logic [63:0] last_mask
);
  logic [2:0] rem;

  assign rem      = len_bytes[2:0];
  assign word_len = (len_bytes + 16'd7) >> 3;

  always_comb begin
    if (rem == 3'd0) begin
      last_ctrl = 8'h01;
      last_mask = {64{1'b1}};
    end else begin
      // ctrl bit marks the last valid byte; bytes fill from the MSB down
      last_ctrl = 8'h80 >> (rem - 3'd1);
      last_mask = ~({64{1'b1}} >> {rem, 3'b000});
    end
  end
endmodule

// File: rtl/pkt_tx_gen.sv
// Packet source: runs of module-header + incrementing-payload packets from latched config.
// Latency: header word 2 edges after the edge that samples start; then 1 word/cycle.
// Backpressure: a word issues only if out_rdy was high the cycle before; FSM holds otherwise.
// Ports: clk/reset, start/stop control, cfg_* run config, tx word bus, busy/done/cfg_err/sent_count status.
module pkt_tx_gen
  import pkt_tx_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_LEN_BYTES = 2048
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [15:0]  cfg_pkt_count,
  input  logic [15:0]  cfg_len_bytes,
  input  logic [7:0]   cfg_ifg,
  input  logic [63:0]  cfg_seed,
  input  logic [15:0]  cfg_src_port,
  input  logic [15:0]  cfg_dst_port,
  pkt_tx_gen_if.master tx,
  output logic         busy,
  output logic         done,
  output logic         cfg_err,
  output logic [31:0]  sent_count
);
  logic [2:0]            state;
  logic [15:0]           pkt_count_q, len_q, src_q, dst_q;
  logic [7:0]            ifg_q;
  logic [63:0]           seed_q;
  logic [15:0]           run_cnt, word_k;
  logic [7:0]            gap_cnt;
  logic                  primed;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic                  wr_q;

  logic [15:0] word_len;
  logic [7:0]  last_ctrl;
  logic [63:0] last_mask;
  logic [63:0] hdr_word, pay_word;
  logic        len_bad, last_word, run_end;

  pkt_len_calc u_len_calc (
    .len_bytes (len_q),
    .word_len  (word_len),
    .last_ctrl (last_ctrl),
    .last_mask (last_mask)
  );

  assign len_bad   = (cfg_len_bytes == 16'd0) || (cfg_len_bytes > 16'(MAX_LEN_BYTES));
  assign last_word = (word_k == word_len - 16'd1);
  assign run_end   = ((run_cnt + 16'd1) == pkt_count_q) || stop;
  assign pay_word  = seed_q + {48'd0, word_k};

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_DST_LSB  +: 16] = dst_q;
    hdr_word[HDR_WLEN_LSB +: 16] = word_len;
    hdr_word[HDR_SRC_LSB  +: 16] = src_q;
    hdr_word[HDR_BLEN_LSB +: 16] = len_q;
  end

  assign tx.out_data = data_q;
  assign tx.out_ctrl = ctrl_q;
  assign tx.out_wr   = wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pkt_count_q <= '0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      ifg_q       <= '0;
      seed_q      <= '0;
      run_cnt     <= '0;
      word_k      <= '0;
      gap_cnt     <= '0;
      primed      <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      wr_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      sent_count  <= '0;
    end else begin
      wr_q <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pkt_count_q <= cfg_pkt_count;
            len_q       <= cfg_len_bytes;
            src_q       <= cfg_src_port;
            dst_q       <= cfg_dst_port;
            ifg_q       <= cfg_ifg;
            seed_q      <= cfg_seed;
            run_cnt     <= '0;
            primed      <= 1'b0;
            if (len_bad) begin
              cfg_err <= 1'b1;
              state   <= ST_DONE;
            end else begin
              cfg_err <= 1'b0;
              if (cfg_pkt_count == 16'd0) begin
                state <= ST_DONE;
              end else begin
                busy  <= 1'b1;
                state <= ST_HDR;
              end
            end
          end
        end
        ST_HDR: begin
          // First header of a run waits one cycle so the length decode sees latched config
          primed <= 1'b1;
          if (primed && tx.out_rdy) begin
            wr_q   <= 1'b1;
            data_q <= hdr_word;
            ctrl_q <= CTRL_MODULE_HDR;
            word_k <= '0;
            state  <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (tx.out_rdy) begin
            wr_q <= 1'b1;
            if (last_word) begin
              data_q     <= pay_word & last_mask;
              ctrl_q     <= last_ctrl;
              sent_count <= sent_count + 32'd1;
              run_cnt    <= run_cnt + 16'd1;
              if (run_end) begin
                state <= ST_DONE;
              end else if (ifg_q == 8'd0) begin
                state <= ST_HDR;
              end else begin
                gap_cnt <= ifg_q;
                state   <= ST_GAP;
              end
            end else begin
              data_q <= pay_word;
              ctrl_q <= CTRL_PAYLOAD;
              word_k <= word_k + 16'd1;
            end
          end
        end
        ST_GAP: begin
          // Gap length is counted in cycles, independent of out_rdy
          if (stop) begin
            state <= ST_DONE;
          end else if (gap_cnt == 8'd1) begin
            state <= ST_HDR;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_tx_gen.sv
// Self-checking bench for pkt_tx_gen: vector table, random runs, stop/reset/start-while-busy sequences.
// Latency: n/a.
// Backpressure: out_rdy driven always-high, toggling, or random per run.
module tb_pkt_tx_gen;
  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] cfg_pkt_count, cfg_len_bytes, cfg_src_port, cfg_dst_port;
  logic [7:0]  cfg_ifg;
  logic [63:0] cfg_seed;
  logic        busy, done, cfg_err;
  logic [31:0] sent_count;

  pkt_tx_gen_if #(.DATA_WIDTH(64)) tx_if ();

  pkt_tx_gen #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_LEN_BYTES(2048)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_len_bytes (cfg_len_bytes),
    .cfg_ifg       (cfg_ifg),
    .cfg_seed      (cfg_seed),
    .cfg_src_port  (cfg_src_port),
    .cfg_dst_port  (cfg_dst_port),
    .tx            (tx_if),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .sent_count    (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [7:0] c; int cyc; } word_t;
  typedef struct {
    int len; int cnt; int ifg; logic [63:0] seed; logic [15:0] src; logic [15:0] dst;
    int mode; logic exp_err; int exp_pkts;
  } vec_t;

  word_t       wq[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_c[$];
  int          cyc = 0, done_cnt = 0, viol = 0, done_cyc = -1, rdy_mode = 0;
  logic        prev_rdy = 1'b0, busy_at_done = 1'b0;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_sent = 0;
  vec_t        tbl[9];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Word / done monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (tx_if.out_wr) begin
      if (!prev_rdy) viol = viol + 1;
      wq.push_back('{tx_if.out_data, tx_if.out_ctrl, cyc});
    end
    if (done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    prev_rdy = tx_if.out_rdy;
  end

  initial begin
    tx_if.out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_if.out_rdy = 1'b1;
        1:       tx_if.out_rdy = ~tx_if.out_rdy;
        default: tx_if.out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference packet stream built directly from the packet format rules
  task automatic build_exp(input int len, input int npkt, input logic [63:0] seed,
                           input logic [15:0] src, input logic [15:0] dst);
    int          wl, r;
    logic [63:0] w;
    wl = (len + 7) / 8;
    r  = len % 8;
    exp_d.delete();
    exp_c.delete();
    for (int p = 0; p < npkt; p++) begin
      exp_d.push_back({dst, 16'(wl), src, 16'(len)});
      exp_c.push_back(8'hFF);
      for (int k = 0; k < wl; k++) begin
        w = seed + 64'(k);
        if (k == wl - 1) begin
          if (r != 0)
            for (int b = r; b < 8; b++) w[(7 - b) * 8 +: 8] = 8'h00;
          exp_d.push_back(w);
          exp_c.push_back(r == 0 ? 8'h01 : 8'(1 << (8 - r)));
        end else begin
          exp_d.push_back(w);
          exp_c.push_back(8'h00);
        end
      end
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_len_bytes = 16'(v.len);
    cfg_pkt_count = 16'(v.cnt);
    cfg_ifg       = 8'(v.ifg);
    cfg_seed      = v.seed;
    cfg_src_port  = v.src;
    cfg_dst_port  = v.dst;
    rdy_mode      = v.mode;
  endtask

  task automatic wait_done(input string nm, output bit got);
    got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      tick();
      if (done_cnt > 0) got = 1;
    end
    check({nm, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic cmp_words(input string nm);
    int f0;
    f0 = n_fail;
    check({nm, "_nwords"}, 64'(wq.size()), 64'(exp_d.size()));
    for (int i = 0; i < wq.size() && i < exp_d.size(); i++) begin
      check($sformatf("%s_data%0d", nm, i), wq[i].d, exp_d[i]);
      check($sformatf("%s_ctrl%0d", nm, i), 64'(wq[i].c), 64'(exp_c[i]));
      if (n_fail > f0) break;
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int start_cyc, wl, last_i, idle;
    bit got;
    drive_cfg(v);
    tick();
    wq.delete(); done_cnt = 0; viol = 0;
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    check({nm, "_busy_after_start"}, 64'(busy), 64'(v.exp_pkts > 0));
    wait_done(nm, got);
    repeat (4) tick();
    if (got) begin
      check({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({nm, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
      check({nm, "_cfg_err"}, 64'(cfg_err), 64'(v.exp_err));
      build_exp(v.len, v.exp_pkts, v.seed, v.src, v.dst);
      cmp_words(nm);
      check({nm, "_rdy_respected"}, 64'(viol), 64'd0);
      exp_sent = exp_sent + 32'(v.exp_pkts);
      check({nm, "_sent_count"}, 64'(sent_count), 64'(exp_sent));
      if (v.exp_pkts == 0)
        check({nm, "_done_latency"}, 64'(done_cyc - start_cyc), 64'd2);
      else if (v.mode == 0 && wq.size() > 0)
        check({nm, "_hdr_latency"}, 64'(wq[0].cyc - start_cyc), 64'd3);
      wl = (v.len + 7) / 8;
      if (wq.size() == exp_d.size()) begin
        for (int p = 0; p + 1 < v.exp_pkts; p++) begin
          last_i = (p + 1) * (wl + 1) - 1;
          idle   = wq[last_i + 1].cyc - wq[last_i].cyc - 1;
          if (v.mode == 0 || (v.mode == 1 && (v.ifg % 2) == 1))
            check($sformatf("%s_gap%0d", nm, p), 64'(idle), 64'(v.ifg));
          else
            check($sformatf("%s_gap_min%0d", nm, p), 64'(idle >= v.ifg), 64'd1);
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    bit   got;
    tbl[0] = '{20,   1, 0, 64'h100, 16'h0001, 16'h0004, 0, 1'b0, 1};
    tbl[1] = '{16,   3, 0, 64'h5000, 16'h0010, 16'h0020, 0, 1'b0, 3};
    tbl[2] = '{64,   2, 5, 64'hFFFF_FFFF_FFFF_FFFE, 16'h0002, 16'h0008, 1, 1'b0, 2};
    tbl[3] = '{0,    1, 0, 64'h1, 16'h1, 16'h2, 0, 1'b1, 0};
    tbl[4] = '{2049, 1, 0, 64'h1, 16'h1, 16'h2, 0, 1'b1, 0};
    tbl[5] = '{8,    1, 0, 64'hABCD, 16'h3, 16'h4, 0, 1'b0, 1};
    tbl[6] = '{10,   0, 0, 64'h9, 16'h3, 16'h4, 0, 1'b0, 0};
    tbl[7] = '{2048, 1, 0, 64'h1234_5678_0000_0000, 16'hBEEF, 16'hCAFE, 2, 1'b0, 1};
    tbl[8] = '{1,    2, 2, 64'hDEAD_BEEF_0000_00FF, 16'h7, 16'h9, 2, 1'b0, 2};

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    v = tbl[5];
    drive_cfg(v);
    repeat (3) tick();
    check("rst_out_wr", 64'(tx_if.out_wr), 64'd0);
    check("rst_out_data", tx_if.out_data, 64'd0);
    check("rst_out_ctrl", 64'(tx_if.out_ctrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_sent", 64'(sent_count), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      if (i == 0 && wq.size() >= 4) begin
        check("len20_hdr", wq[0].d, 64'h0004_0003_0001_0014);
        check("len20_w1", wq[1].d, 64'h100);
        check("len20_last", wq[3].d, 64'h0);
        check("len20_last_ctrl", 64'(wq[3].c), 64'h10);
      end
      if (i == 1 && wq.size() >= 9)
        check("len16_b2b_span", 64'(wq[8].cyc - wq[0].cyc), 64'd8);
    end

    for (int i = 0; i < 6; i++) begin
      v.len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2049, 3000))
                                           : int'($urandom_range(0, 300));
      v.cnt  = $urandom_range(1, 3);
      v.ifg  = $urandom_range(0, 4);
      v.seed = {$urandom, $urandom};
      v.src  = 16'($urandom);
      v.dst  = 16'($urandom);
      v.mode = $urandom_range(0, 2);
      v.exp_err  = (v.len == 0) || (v.len > 2048);
      v.exp_pkts = v.exp_err ? 0 : v.cnt;
      run(v, $sformatf("rnd%0d", i));
    end

    // stop during packet 2, with an ignored start pulse mid-run
    v = '{100, 10, 3, 64'h7700, 16'h11, 16'h22, 0, 1'b0, 2};
    drive_cfg(v);
    tick();
    wq.delete(); done_cnt = 0; viol = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && wq.size() < 5; i++) tick();
    cfg_len_bytes = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && wq.size() < 17; i++) tick();
    stop = 1'b1;
    wait_done("stop", got);
    stop = 1'b0;
    repeat (4) tick();
    check("stop_done_pulses", 64'(done_cnt), 64'd1);
    build_exp(100, 2, v.seed, v.src, v.dst);
    cmp_words("stop");
    exp_sent = exp_sent + 32'd2;
    check("stop_sent_count", 64'(sent_count), 64'(exp_sent));
    check("stop_busy", 64'(busy), 64'd0);

    // reset mid-payload, with a start coincident with reset
    v = '{100, 2, 0, 64'h4400, 16'h5, 16'h6, 0, 1'b0, 2};
    drive_cfg(v);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && wq.size() < 5; i++) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_out_wr", 64'(tx_if.out_wr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sent", 64'(sent_count), 64'd0);
    check("midrst_data", tx_if.out_data, 64'd0);
    reset = 1'b0;
    exp_sent = 0;
    wq.delete();
    repeat (4) tick();
    check("midrst_start_ignored_busy", 64'(busy), 64'd0);
    check("midrst_start_ignored_words", 64'(wq.size()), 64'd0);
    run('{24, 1, 0, 64'h6600, 16'hA, 16'hB, 0, 1'b0, 1}, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_tx_gen.md
Name: pkt_tx_gen

Overview:
- Packet source for the user data path word stream: generates NetFPGA-format packets (module header word, then payload words) onto `out_data/out_ctrl/out_wr` under `out_rdy` flow control.
- It is the transmitter counterpart of the datapath receive port. It drives a datapath `in_*` port in benches and on-chip loopback self-test.
- Configuration comes from software registers and is latched on `start`. Status is returned as hardware registers.

Parameters:
- DATA_WIDTH, 64, word width; only 64 supported.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- MAX_LEN_BYTES, 2048, largest accepted packet byte length.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begin a run; ignored while busy.
- stop  in  1  level; end the run at the next packet boundary.
- cfg_pkt_count  in  16  packets per run; 0 means no packets.
- cfg_len_bytes  in  16  payload byte length per packet; valid range 1..MAX_LEN_BYTES.
- cfg_ifg  in  8  idle cycles between packets.
- cfg_seed  in  64  payload pattern base.
- cfg_src_port  in  16  header source port field.
- cfg_dst_port  in  16  header destination port field.
- out_data  out  DATA_WIDTH  word.
- out_ctrl  out  CTRL_WIDTH  ctrl byte.
- out_wr  out  1  word valid.
- out_rdy  in  1  downstream can accept a word.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- cfg_err  out  1  sticky; length out of range on last start; cleared by next valid start.
- sent_count  out  32  packets completed since reset.

Behaviour:
- Reset values: out_data=0, out_ctrl=0, out_wr=0, busy=0, done=0, cfg_err=0, sent_count=0, FSM in IDLE.
- Outputs are registered. A word is issued at edge E only if `out_rdy`=1 in the cycle before E. `out_wr` is 1 for exactly one cycle per word, and `out_data/out_ctrl` hold that word. When a word is not issued, `out_wr`=0 and data/ctrl keep their last values.
- `start` sampled high in IDLE:
  - all cfg_* inputs are latched;
  - if cfg_len_bytes is 0 or greater than MAX_LEN_BYTES: cfg_err=1, done pulses at the next edge, no packets are sent;
  - else if cfg_pkt_count is 0: done pulses at the next edge;
  - otherwise the FSM enters HDR with busy=1.
- Latency: with out_rdy=1, the header carries out_wr=1 two edges after the edge that samples start. Throughput is then 1 word/cycle.
- FSM states: IDLE -> HDR -> PAYLOAD -> (GAP ->) HDR ... -> DONE -> IDLE.
- HDR: issue header word with `out_ctrl`=8'hFF and `out_data` = {dst_port[63:48], word_len[47:32], src_port[31:16], byte_len[15:0]}.
  - word_len = ceil(len/8), computed in 16 bits.
  - Then go to PAYLOAD with k=0.
- PAYLOAD: word k has `out_data` = cfg_seed + k, mod 2^64.
  - Non-last words have `out_ctrl`=8'h00.
  - On the last word (k = word_len-1), let r = len mod 8: `out_ctrl` = 8'h01 if r=0, else 8'h80 >> (r-1).
  - Valid bytes are MSB-first; invalid bytes of the last word are forced to 0.
  - Issuing the last word increments sent_count (wraps at 2^32) and the run packet counter.
- After the last word:
  - if the run packet count is reached, or stop=1: go to DONE;
  - else if cfg_ifg=0: go to HDR, back-to-back;
  - else go to GAP and hold out_wr=0 for exactly cfg_ifg cycles, counted regardless of out_rdy, then go to HDR.
- stop is checked only at packet boundaries (last word issued, or in GAP). stop=1 in GAP goes to DONE immediately. Packets are never truncated by stop.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- out_rdy low mid-packet: the FSM stalls and its state and counters hold. There is no timeout.
- Reset mid-packet: outputs return to reset values at that edge and the packet is truncated. Downstream must be reset together with this block.
- A start pulse while busy is ignored and does not disturb the run. A start coincident with reset is ignored.

Decomposition:
- Shared package:
  - CTRL_MODULE_HDR = 8'hFF;
  - CTRL_PAYLOAD = 8'h00;
  - header field bit positions;
  - FSM state encoding (IDLE, HDR, PAYLOAD, GAP, DONE).
- Sub-module `pkt_len_calc` (combinational on latched length): outputs word_len[15:0], last_ctrl[7:0] and last_mask[63:0]. It is reused by the receiver-side checker.

Test Plan:
- len=20, count=1, seed=0x100, src=0x0001, dst=0x0004, out_rdy=1 ->
  - header 0x0004_0003_0001_0014 with ctrl FF;
  - words 0x100 and 0x101 with ctrl 00;
  - 0x0000_0102_0000_0000 is wrong; the required third word is 0x0000_0000_0000_0000 (upper 4 bytes of 0x102 are 0) with ctrl 0x10;
  - done pulse; sent_count=1.
- len=16, count=3, ifg=0 -> 9 consecutive out_wr cycles; last ctrl 0x01 on words 3, 6 and 9; sent_count=3.
- len=64, count=2, ifg=5, out_rdy toggling 1/0 each cycle -> no out_wr in a cycle after out_rdy=0; exactly 5 idle cycles between the packets after the last word; payloads intact.
- len=0 and len=2049 -> cfg_err=1, done after 1 edge, no out_wr. Then len=8, count=1 -> cfg_err clears; last ctrl 0x01.
- count=10, len=100, stop raised during the 2nd packet's payload -> the 2nd packet completes, done, sent_count=2. A start pulsed mid-run is ignored.
- Reset asserted during payload -> next edge out_wr=0, busy=0, sent_count=0. A subsequent start gives a normal run from the header.
